// File: rtl/cmsdk_uart_stim_pkg.sv
// Shared constants for the UART stimulus transmitter.
// State encoding and frame sizing.
package cmsdk_uart_stim_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

    function automatic int frame_cycles(input int baud, input int gap);
        return (FRAME_BITS + gap) * baud;
    endfunction

endpackage

// File: rtl/cmsdk_tb_byte_fifo.sv
// Byte FIFO with occupancy count for the UART stimulus.
// Power-of-2 depth; pointers wrap naturally.
module cmsdk_tb_byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = CW - 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign empty   = (count == '0);
    assign wr_ok   = wr_en && (count != CW'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmsdk_uart_stimulus.sv
// Testbench-side UART transmitter: queues bytes and sends 8N1 frames
// into the MCU RXD pin, with optional idle bit-times after each stop bit.
module cmsdk_uart_stimulus
    import cmsdk_uart_stim_pkg::*;
#(
    parameter int BAUDDIV    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_BITS   = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       TXD,
    output logic       BUSY,
    output logic       EMPTY,
    output logic       TXDONE
);

    localparam int         CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int         TW         = $clog2(BAUDDIV);
    localparam logic [TW-1:0] BAUD_LAST = TW'(BAUDDIV - 1);
    localparam int         GAP_LAST_I = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
    localparam logic [3:0] GAP_LAST   = 4'(GAP_LAST_I);

    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [TW-1:0] timer;
    logic          bit_end;
    logic [2:0]    bit_idx;
    logic [3:0]    gap_cnt;
    logic [7:0]    shift;
    logic          txd_q;
    logic          txd_next;

    assign DIN_READY = (fifo_count != CW'(FIFO_DEPTH));
    assign push      = DIN_VALID & DIN_READY;
    assign EMPTY     = fifo_empty;
    assign BUSY      = (state != IDLE) | ~fifo_empty;
    assign TXD       = txd_q;
    assign bit_end   = (timer == BAUD_LAST);

    cmsdk_tb_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .reset   (RESET),
        .wr_en   (push),
        .wr_data (DIN),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!fifo_empty) next_state = START;
            START:   if (bit_end) next_state = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) next_state = STOP;
            STOP:    if (bit_end) next_state = (GAP_BITS > 0) ? GAP : IDLE;
            GAP:     if (bit_end && gap_cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // TXD is registered, so it follows the state being entered
    always_comb begin
        pop      = (state == IDLE) && !fifo_empty;
        TXDONE   = (state == STOP) && bit_end;
        txd_next = 1'b1;
        unique case (next_state)
            START:   txd_next = 1'b0;
            DATA:    txd_next = (state == DATA && bit_end) ? shift[1] : shift[0];
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            timer   <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            shift   <= '0;
            txd_q   <= 1'b1;
        end else begin
            txd_q <= txd_next;
            if (state == IDLE || next_state != state || bit_end) timer <= '0;
            else timer <= timer + 1'b1;
            if (pop) shift <= fifo_dout;
            else if (state == DATA && bit_end) shift <= {1'b0, shift[7:1]};
            if (state != DATA) bit_idx <= '0;
            else if (bit_end) bit_idx <= bit_idx + 1'b1;
            if (state != GAP) gap_cnt <= '0;
            else if (bit_end) gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmsdk_uart_stimulus.sv
// Directed bench for cmsdk_uart_stimulus: frame timing, FIFO
// back-pressure, idle gap, mid-frame reset and a short string.
module tb_cmsdk_uart_stimulus;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;
    logic       val0 = 1'b0;
    logic       val1 = 1'b0;
    logic       rdy0, txd0, busy0, emp0, done0;
    logic       rdy1, txd1, busy1, emp1, done1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt0 = 0;
    int last_done0 = -1;
    int last_start0 = -1;
    logic p_txd0 = 1'b1;

    logic [7:0] rx0_q[$];
    logic [7:0] rx1_q[$];
    int rx0_fe = 0;
    int rx1_fe = 0;

    always #5 clk = ~clk;

    cmsdk_uart_stimulus #(
        .BAUDDIV(16), .FIFO_DEPTH(8), .GAP_BITS(0)
    ) dut0 (
        .CLK(clk), .RESET(rst), .DIN(din0), .DIN_VALID(val0),
        .DIN_READY(rdy0), .TXD(txd0), .BUSY(busy0), .EMPTY(emp0),
        .TXDONE(done0)
    );

    cmsdk_uart_stimulus #(
        .BAUDDIV(16), .FIFO_DEPTH(8), .GAP_BITS(2)
    ) dut1 (
        .CLK(clk), .RESET(rst), .DIN(din1), .DIN_VALID(val1),
        .DIN_READY(rdy1), .TXD(txd1), .BUSY(busy1), .EMPTY(emp1),
        .TXDONE(done1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            done_cnt0  <= done_cnt0 + 1;
            last_done0 <= cyc;
        end
        if (p_txd0 === 1'b1 && txd0 === 1'b0) last_start0 <= cyc;
        p_txd0 <= txd0;
    end

    // Serial receivers sampling mid-bit
    always begin : mon0
        logic [7:0] b;
        @(negedge txd0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = txd0;
        end
        repeat (16) @(negedge clk);
        if (txd0 === 1'b1) rx0_q.push_back(b);
        else rx0_fe++;
    end

    always begin : mon1
        logic [7:0] b;
        @(negedge txd1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = txd1;
        end
        repeat (16) @(negedge clk);
        if (txd1 === 1'b1) rx1_q.push_back(b);
        else rx1_fe++;
    end

    task automatic do_reset();
        rst  = 1'b1;
        val0 = 1'b0;
        val1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input int d, input logic [7:0] b, output bit ok);
        int t = 0;
        if (d == 0) begin din0 = b; val0 = 1'b1; end
        else        begin din1 = b; val1 = 1'b1; end
        while (((d == 0) ? rdy0 : rdy1) !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        val0 = 1'b0;
        val1 = 1'b0;
        ok = (t < 2000);
    endtask

    task automatic test_reset();
        int bad_txd = 0, bad_rdy = 0, bad_emp = 0, bad_busy = 0, bad_done = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || txd1 !== 1'b1) bad_txd++;
            if (rdy0 !== 1'b1 || rdy1 !== 1'b1) bad_rdy++;
            if (emp0 !== 1'b1 || emp1 !== 1'b1) bad_emp++;
            if (busy0 !== 1'b0 || busy1 !== 1'b0) bad_busy++;
            if (done0 !== 1'b0 || done1 !== 1'b0) bad_done++;
        end
        rst = 1'b0;
        checks++;
        if (bad_txd !== 0) begin errors++; $display("FAIL reset_txd bad_cycles %0d want 0", bad_txd); end
        checks++;
        if (bad_rdy !== 0) begin errors++; $display("FAIL reset_ready bad_cycles %0d want 0", bad_rdy); end
        checks++;
        if (bad_emp !== 0) begin errors++; $display("FAIL reset_empty bad_cycles %0d want 0", bad_emp); end
        checks++;
        if (bad_busy !== 0) begin errors++; $display("FAIL reset_busy bad_cycles %0d want 0", bad_busy); end
        checks++;
        if (bad_done !== 0) begin errors++; $display("FAIL reset_txdone bad_cycles %0d want 0", bad_done); end
    endtask

    task automatic test_single_frame();
        logic [7:0] v = 8'hA5;
        int base, first_bad = -1, done_k = -1, pulses = 0;
        logic exp;
        bit ok;
        do_reset();
        base = rx0_q.size();
        push(0, v, ok);
        checks++;
        if (emp0 !== 1'b0 || busy0 !== 1'b1 || txd0 !== 1'b1) begin
            errors++;
            $display("FAIL latency_write got empty=%b busy=%b txd=%b want 0 1 1", emp0, busy0, txd0);
        end
        for (int k = 1; k <= 161; k++) begin
            @(negedge clk);
            if (k <= 16) exp = 1'b0;
            else if (k <= 144) exp = v[(k - 17) / 16];
            else exp = 1'b1;
            if (txd0 !== exp && first_bad < 0) first_bad = k;
            if (done0 === 1'b1) begin
                pulses++;
                if (done_k < 0) done_k = k;
            end
        end
        checks++;
        if (first_bad != -1) begin errors++; $display("FAIL frame_a5_wave first_bad_cycle %0d want none", first_bad); end
        checks++;
        if (done_k != 160) begin errors++; $display("FAIL frame_a5_txdone cycle %0d want 160", done_k); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL frame_a5_pulses got %0d want 1", pulses); end
        repeat (4) @(negedge clk);
        checks++;
        if (rx0_q.size() != base + 1) begin
            errors++;
            $display("FAIL frame_a5_rx_count got %0d want 1", rx0_q.size() - base);
        end else if (rx0_q[base] !== 8'hA5) begin
            errors++;
            $display("FAIL frame_a5_rx_byte got %h want a5", rx0_q[base]);
        end
        checks++;
        if (busy0 !== 1'b0 || emp0 !== 1'b1) begin
            errors++;
            $display("FAIL frame_a5_idle got busy=%b empty=%b want 0 1", busy0, emp0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [9];
        int base, n0, t, dsnap, bad = 0;
        bit ok;
        do_reset();
        base  = rx0_q.size();
        dsnap = done_cnt0;
        exp[0] = 8'h11;
        for (int i = 1; i < 9; i++) exp[i] = 8'h20 + 8'(i);
        push(0, exp[0], ok);
        n0 = cyc;
        repeat (2) @(negedge clk);
        for (int i = 1; i < 9; i++) push(0, exp[i], ok);
        checks++;
        if (rdy0 !== 1'b0 || emp0 !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full got ready=%b empty=%b want 0 0", rdy0, emp0);
        end
        t = 0;
        while (rdy0 !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        #1;
        checks++;
        if (cyc != n0 + 162) begin errors++; $display("FAIL ready_rise cycle %0d want %0d", cyc - n0, 162); end
        checks++;
        if (last_start0 - last_done0 != 2) begin
            errors++;
            $display("FAIL idle_between_frames got %0d want 2", last_start0 - last_done0);
        end
        t = 0;
        while (busy0 !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rx0_q.size() != base + 9) begin
            errors++;
            $display("FAIL b2b_rx_count got %0d want 9", rx0_q.size() - base);
        end else begin
            for (int i = 0; i < 9; i++) if (rx0_q[base + i] !== exp[i]) bad++;
            if (bad != 0) begin errors++; $display("FAIL b2b_rx_order bad_bytes %0d want 0", bad); end
        end
        checks++;
        if (done_cnt0 - dsnap != 9) begin
            errors++;
            $display("FAIL b2b_txdone got %0d want 9", done_cnt0 - dsnap);
        end
    endtask

    task automatic test_gap();
        int base, n0, td = -1, ts = -1, t;
        bit ok;
        do_reset();
        base = rx1_q.size();
        push(1, 8'h3C, ok);
        n0 = cyc;
        push(1, 8'hC3, ok);
        t = 0;
        while (done1 !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (done1 === 1'b1) td = cyc;
        @(negedge clk);
        t = 0;
        while (txd1 !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (txd1 === 1'b0) ts = cyc;
        checks++;
        if (td - n0 != 160) begin errors++; $display("FAIL gap_first_done cycle %0d want 160", td - n0); end
        checks++;
        if (ts - td != 34) begin errors++; $display("FAIL gap_restart got %0d want 34", ts - td); end
        t = 0;
        while (busy1 !== 1'b0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rx1_q.size() != base + 2 || rx1_fe != 0) begin
            errors++;
            $display("FAIL gap_rx_count got %0d fe %0d want 2 0", rx1_q.size() - base, rx1_fe);
        end else if (rx1_q[base] !== 8'h3C || rx1_q[base + 1] !== 8'hC3) begin
            errors++;
            $display("FAIL gap_rx_bytes got %h %h want 3c c3", rx1_q[base], rx1_q[base + 1]);
        end
    endtask

    task automatic test_reset_midframe();
        int n0, dsnap, low = 0;
        bit ok;
        do_reset();
        push(0, 8'h55, ok);
        n0 = cyc;
        push(0, 8'h66, ok);
        push(0, 8'h77, ok);
        push(0, 8'h88, ok);
        while (cyc < n0 + 70) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || emp0 !== 1'b0) begin
            errors++;
            $display("FAIL midframe_pre got busy=%b empty=%b want 1 0", busy0, emp0);
        end
        #1;
        dsnap = done_cnt0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txd0 !== 1'b1 || emp0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset got txd=%b empty=%b busy=%b ready=%b want 1 1 0 1",
                     txd0, emp0, busy0, rdy0);
        end
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1) low++;
        end
        checks++;
        if (low != 0) begin errors++; $display("FAIL midframe_no_resume low_cycles %0d want 0", low); end
        #1;
        checks++;
        if (done_cnt0 != dsnap) begin
            errors++;
            $display("FAIL midframe_txdone got %0d want 0", done_cnt0 - dsnap);
        end
        @(negedge clk);
    endtask

    task automatic test_string();
        logic [7:0] s [6];
        int base, dsnap, t, bad = 0;
        bit ok;
        s[0] = 8'h48; s[1] = 8'h65; s[2] = 8'h6C;
        s[3] = 8'h6C; s[4] = 8'h6F; s[5] = 8'h0A;
        do_reset();
        base  = rx0_q.size();
        dsnap = done_cnt0;
        for (int i = 0; i < 6; i++) push(0, s[i], ok);
        t = 0;
        while (busy0 !== 1'b0 && t < 1500) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rx0_q.size() != base + 6) begin
            errors++;
            $display("FAIL string_count got %0d want 6", rx0_q.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) if (rx0_q[base + i] !== s[i]) bad++;
            if (bad != 0) begin errors++; $display("FAIL string_bytes bad_bytes %0d want 0", bad); end
        end
        #1;
        checks++;
        if (done_cnt0 - dsnap != 6) begin
            errors++;
            $display("FAIL string_txdone got %0d want 6", done_cnt0 - dsnap);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap();
        test_reset_midframe();
        test_string();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
